md_unit: RTL
============

Name: md_unit

Overview:
- Multiply/divide unit in the E stage, with HI/LO registers.
- Produces the Busy signal and accepts the Start pulse consumed by the pipeline hazard logic.
- The hazard logic stalls any mult/div/mfhi/mflo/mthi/mtlo in D while Start or Busy is high.
- Latches operands on Start, models multi-cycle latency with a down-counter, and commits results to HI/LO when the operation ends.

Parameters:
- MUL_LAT, 5, Busy cycles for mult/multu (must be ≥1).
- DIV_LAT, 10, Busy cycles for div/divu (must be ≥1).

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-low reset (Reset==0 at a Clk edge resets).
- Start  input  1  one-cycle pulse from E stage; launches the op in MDOp.
- MDOp  input  4  operation code (md_* constants): none, mult, multu, div, divu, mthi, mtlo, madd, maddu.
- A  input  32  rs operand (forwarded value).
- B  input  32  rt operand (forwarded value).
- Flush  input  1  exception/interrupt cancel for the E-stage instruction.
- Busy  output  1  operation in flight.
- HI  output  32  HI register.
- LO  output  32  LO register.

Behaviour:
- Reset (Reset==0 at edge): HI=0, LO=0, Busy=0, counter=0, state IDLE. Reset aborts any op in flight; no commit.
- States:
  - IDLE: Busy=0.
  - RUN: Busy=1, counter counts down.
- IDLE->RUN: Start=1, MDOp in {mult,multu,div,divu[,madd,maddu]}, Flush=0.
  - Latch A, B, MDOp.
  - Load counter with MUL_LAT-1 (mult/madd) or DIV_LAT-1 (div).
  - Busy rises the cycle after Start.
  - Start itself is a combinational input visible to the hazard logic in the Start cycle.
- RUN: counter decrements each cycle.
  - At the edge where counter==0: commit HI/LO, go to IDLE.
  - Busy is high for exactly MUL_LAT or DIV_LAT cycles; new HI/LO is visible the cycle Busy falls.
- mthi/mtlo: with Start=1 and Flush=0 in IDLE, write A to HI or LO at that edge; no Busy.
- Start while in RUN: ignored, no effect. The hazard logic guarantees this never happens; assertion in the bench.
- Flush=1 with Start=1: start suppressed, HI/LO unchanged.
- Flush while in RUN does not abort (the instruction has already passed E).
- Arithmetic:
  - mult: {HI,LO} = signed(A)*signed(B), 64-bit.
  - multu: unsigned product.
  - div: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - divu: unsigned quotient/remainder.
  - Divisor==0: run full latency, HI/LO unchanged.
  - 0x80000000 / -1: LO=0x80000000, HI=0.
- Computation uses the latched operands only; changes on A/B during RUN are irrelevant.
- MDOp none or unknown with Start=1: no state change.

Optional Feature:
- MD_MADD_EN defined: madd/maddu accepted.
  - {HI,LO} += 64-bit signed/unsigned product of latched A, B; wraps modulo 2^64.
  - Latency MUL_LAT.
  - The accumulation base is HI/LO as sampled at the commit edge.
- Not defined: madd/maddu codes are treated as unknown (no-op, no Busy).

Decomposition:
- Shared macros file holds:
  - md_* op codes (4-bit).
  - Default latencies.
- These are shared with the controller and hazard decoder.
- One natural sub-module, md_arith: combinational 64-bit result from latched op/A/B and current HI/LO. md_unit keeps the FSM, counter, operand latches and HI/LO.

Test Plan:
- Reset=0 for 2 cycles -> HI=0, LO=0, Busy=0. Mid-run reset (cycle 3 of a div) -> Busy=0 next cycle, HI/LO=0.
- mult A=0xFFFFFFFE (-2), B=3, Start pulse -> Busy=1 for cycles 1..5 after Start; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. multu with same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- div A=-7, B=2 -> Busy 10 cycles; LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). divu A=7, B=0 -> Busy 10 cycles, HI/LO unchanged.
- mthi A=0x12345678 -> HI=0x12345678 next cycle, Busy stays 0. mtlo with Flush=1 -> LO unchanged.
- mult Start with Flush=1 -> Busy stays 0, HI/LO unchanged. Change A/B during RUN -> result still uses the Start-cycle operands.
- MD_MADD_EN: HI=0, LO=0xFFFFFFFF, maddu A=1, B=1 -> HI=1, LO=0 after 5 cycles. Without the macro, the same stimulus -> no Busy, HI/LO unchanged.

Source files
------------

// File: rtl/md_unit_pkg.sv
// Shared op codes, default latencies and op-class helpers for the multiply/divide unit.
// MD_MADD_EN enables the madd/maddu accumulate ops.
package md_unit_pkg;

    typedef logic [3:0] md_op_t;

    localparam md_op_t MD_NONE  = 4'd0;
    localparam md_op_t MD_MULT  = 4'd1;
    localparam md_op_t MD_MULTU = 4'd2;
    localparam md_op_t MD_DIV   = 4'd3;
    localparam md_op_t MD_DIVU  = 4'd4;
    localparam md_op_t MD_MTHI  = 4'd5;
    localparam md_op_t MD_MTLO  = 4'd6;
    localparam md_op_t MD_MADD  = 4'd7;
    localparam md_op_t MD_MADDU = 4'd8;

    localparam int MD_MUL_LAT_DEF = 5;
    localparam int MD_DIV_LAT_DEF = 10;

    function automatic logic md_is_div(md_op_t op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    // Ops that occupy the unit for several cycles and commit HI/LO at the end.
    function automatic logic md_is_long(md_op_t op);
`ifdef MD_MADD_EN
        return (op == MD_MULT) || (op == MD_MULTU) || md_is_div(op) ||
               (op == MD_MADD) || (op == MD_MADDU);
`else
        return (op == MD_MULT) || (op == MD_MULTU) || md_is_div(op);
`endif
    endfunction

endpackage

// File: rtl/md_unit_if.sv
// E-stage request / HI-LO result bundle between the pipeline and the multiply/divide unit.
interface md_unit_if;
    import md_unit_pkg::*;

    logic        Start;
    md_op_t      MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Flush;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (output Start, MDOp, A, B, Flush, input Busy, HI, LO);
    modport slave  (input Start, MDOp, A, B, Flush, output Busy, HI, LO);
endinterface

// File: rtl/md_unit_arith.sv
// Combinational 64-bit {HI,LO} result for the latched op/operands; o_wr=0 means leave HI/LO alone.
// With MD_MADD_EN the current HI/LO are inputs so madd/maddu can accumulate.
module md_unit_arith
    import md_unit_pkg::*;
(
    input  md_op_t      i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
`ifdef MD_MADD_EN
    input  logic [31:0] i_hi,
    input  logic [31:0] i_lo,
`endif
    output logic [63:0] o_res,
    output logic        o_wr
);
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_neg_a;
    logic        w_neg_b;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic [31:0] w_sq;
    logic [31:0] w_sr;

    assign w_prod_s = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
    assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

    // Signed divide on magnitudes; 0x80000000 / -1 naturally yields 0x80000000 rem 0.
    assign w_neg_a = i_a[31];
    assign w_neg_b = i_b[31];
    assign w_mag_a = w_neg_a ? -i_a : i_a;
    assign w_mag_b = w_neg_b ? -i_b : i_b;
    assign w_uq    = w_mag_a / w_mag_b;
    assign w_ur    = w_mag_a % w_mag_b;
    assign w_sq    = (w_neg_a ^ w_neg_b) ? -w_uq : w_uq;
    assign w_sr    = w_neg_a ? -w_ur : w_ur;

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        o_res = '0;
        o_wr  = 1'b0;
        case (i_op)
            MD_MULT:  begin o_res = w_prod_s;           o_wr = 1'b1;  end
            MD_MULTU: begin o_res = w_prod_u;           o_wr = 1'b1;  end
            MD_DIV:   begin o_res = {w_sr, w_sq};       o_wr = |i_b;  end
            MD_DIVU:  begin o_res = {i_a % i_b, i_a / i_b}; o_wr = |i_b; end
`ifdef MD_MADD_EN
            MD_MADD:  begin o_res = {i_hi, i_lo} + w_prod_s; o_wr = 1'b1; end
            MD_MADDU: begin o_res = {i_hi, i_lo} + w_prod_u; o_wr = 1'b1; end
`endif
            default:  ;
        endcase
    end
endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit: IDLE/RUN control, latency down-counter, operand latches, HI/LO.
// Define MD_MADD_EN to accept madd/maddu.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MUL_LAT = MD_MUL_LAT_DEF,
    parameter int DIV_LAT = MD_DIV_LAT_DEF
) (
    input  logic      Clk,
    input  logic      Reset,
    md_unit_if.slave  md
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam int LAT_MAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    md_op_t           r_op;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic [63:0]      w_res;
    logic             w_wr;

    md_unit_arith u_arith (
        .i_op  (r_op),
        .i_a   (r_a),
        .i_b   (r_b),
`ifdef MD_MADD_EN
        .i_hi  (r_hi),
        .i_lo  (r_lo),
`endif
        .o_res (w_res),
        .o_wr  (w_wr)
    );

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_op    <= MD_NONE;
            r_a     <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else if (r_state == ST_RUN) begin
            // Start and Flush are ignored here: the instruction has already left E.
            if (r_cnt == '0) begin
                r_state <= ST_IDLE;
                if (w_wr) begin
                    r_hi <= w_res[63:32];
                    r_lo <= w_res[31:0];
                end
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end else if (md.Start && !md.Flush) begin
            if (md_is_long(md.MDOp)) begin
                r_state <= ST_RUN;
                r_op    <= md.MDOp;
                r_a     <= md.A;
                r_b     <= md.B;
                r_cnt   <= md_is_div(md.MDOp) ? DIV_CNT : MUL_CNT;
            end else if (md.MDOp == MD_MTHI) begin
                r_hi <= md.A;
            end else if (md.MDOp == MD_MTLO) begin
                r_lo <= md.A;
            end
        end
    end

    assign md.Busy = (r_state == ST_RUN);
    assign md.HI   = r_hi;
    assign md.LO   = r_lo;
endmodule
